decode: RTL and testbench

- Instruction decode stage directly downstream of fetch and instruction memory in the pd core.
- Accepts {pc, insn} pairs through a valid/ready handshake. Splits RV32I fields, builds the sign-extended immediate and flags illegal encodings.
- Holds results in a registered output stage backed by a one-entry skid buffer, so full throughput holds even when ready_i drops.

---
 rtl/decode.sv | 165 ++++++++++++++++
 tb/tb_decode.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// RV32I decode stage: splits fields, builds the immediate and flags illegal opcodes behind
// a registered output with a one-entry skid buffer. DECODE_PERF_CNT_EN adds transfer counters.
module decode #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       decoded_cnt_o,
    output logic [31:0]       illegal_cnt_o
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [DWIDTH-1:0] imm;
        logic              illegal;
    } bundle_t;

    // Encoding chosen so bit 0 is OUT valid and bit 1 is SKID valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t  state, state_nxt;
    bundle_t dec, out_q, skid_q;
    logic    accept, load_out, out_from_skid, load_skid;

    assign valid_o = state[0];
    assign ready_o = ~state[1];
    assign accept  = valid_i & ready_o;

    // Combinational decode of the incoming word; all listed opcodes end in 2'b11.
    always_comb begin
        dec         = '0;
        dec.pc      = pc_i;
        dec.insn    = insn_i;
        dec.imm     = '0;
        dec.illegal = 1'b0;
        case (insn_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
            OP_STORE:
                dec.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OP_BRANCH:
                dec.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                           insn_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec.imm = {insn_i[31:12], 12'b0};
            OP_JAL:
                dec.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                           insn_i[30:21], 1'b0};
            OP_REG:
                dec.imm = '0;
            default:
                dec.illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !ready_i)      state_nxt = FULL;
                else if (!accept && ready_i) state_nxt = EMPTY;
            end
            FULL:    if (ready_i) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Datapath load controls
    always_comb begin
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: load_out = accept;
            ONE: begin
                load_out  = accept & ready_i;
                load_skid = accept & ~ready_i;
            end
            FULL: begin
                load_out      = ready_i;
                out_from_skid = ready_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign pc_o      = out_q.pc;
    assign insn_o    = out_q.insn;
    assign imm_o     = out_q.imm;
    assign illegal_o = out_q.illegal;
    assign opcode_o  = out_q.insn[6:0];
    assign rd_o      = out_q.insn[11:7];
    assign funct3_o  = out_q.insn[14:12];
    assign rs1_o     = out_q.insn[19:15];
    assign rs2_o     = out_q.insn[24:20];
    assign funct7_o  = out_q.insn[31:25];

`ifdef DECODE_PERF_CNT_EN
    // Counters advance on output transfers and wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decoded_cnt_o <= '0;
            illegal_cnt_o <= '0;
        end else if (valid_o && ready_i) begin
            decoded_cnt_o <= decoded_cnt_o + 32'd1;
            if (out_q.illegal) illegal_cnt_o <= illegal_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed test-plan cases plus randomized traffic against a queue model.
module tb_decode;

    logic        clk, rst;
    logic        valid_i, ready_o, valid_o, ready_i;
    logic [31:0] pc_i, insn_i, pc_o, insn_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic        illegal_o;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] decoded_cnt_o, illegal_cnt_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int unsigned m_dec = 0;
    int unsigned m_ill = 0;

    decode dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .insn_i(insn_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o),
        .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .funct7_o(funct7_o), .imm_o(imm_o), .illegal_o(illegal_o)
`ifdef DECODE_PERF_CNT_EN
        , .decoded_cnt_o(decoded_cnt_o), .illegal_cnt_o(illegal_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    function automatic bit is_legal(input logic [31:0] w);
        int unsigned op = w & 32'h7f;
        return op inside {'h03, 'h13, 'h67, 'h73, 'h23, 'h63, 'h37, 'h17, 'h6f, 'h33};
    endfunction

    // Immediate computed arithmetically from the instruction-format bit positions.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int unsigned op = w & 32'h7f;
        int v;
        case (op)
            'h03, 'h13, 'h67, 'h73: return 32'($signed(w) >>> 20);
            'h23: return 32'((($signed(w) >>> 25) * 32) + int'((w >> 7) & 31));
            'h63: begin
                v = int'(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048
                       + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2);
                if (v >= 4096) v -= 8192;
                return 32'(v);
            end
            'h37, 'h17: return w & 32'hFFFFF000;
            'h6f: begin
                v = int'(((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 255) * (1 << 12)
                       + ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2);
                if (v >= (1 << 20)) v -= (1 << 21);
                return 32'(v);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w = $urandom;
        int unsigned k = $urandom_range(0, 13);
        case (k)
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h67;
            3: w[6:0] = 7'h73;  4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;  8: w[6:0] = 7'h6f;
            9: w[6:0] = 7'h33;  10: w[6:0] = 7'h63;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard: occupancy drives expected handshakes, queue head drives expected data.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
        end else begin
            check("valid_o", 32'(valid_o), 32'(q.size() > 0));
            check("ready_o", 32'(ready_o), 32'(q.size() < 2));
`ifdef DECODE_PERF_CNT_EN
            check("decoded_cnt", decoded_cnt_o, m_dec);
            check("illegal_cnt", illegal_cnt_o, m_ill);
`endif
            if (valid_o && q.size() > 0) begin
                e = q[0];
                check("pc_o", pc_o, e.pc);
                check("insn_o", insn_o, e.insn);
                check("fields", {funct7_o, rs2_o, rs1_o, funct3_o, rd_o, opcode_o}, e.insn);
                check("imm_o", imm_o, e.imm);
                check("illegal_o", 32'(illegal_o), 32'(e.ill));
                if (ready_i) begin
                    void'(q.pop_front());
                    m_dec++;
                    if (e.ill) m_ill++;
                end
            end
            if (valid_i && ready_o) begin
                e.pc   = pc_i;
                e.insn = insn_i;
                e.imm  = is_legal(insn_i) ? ref_imm(insn_i) : 32'd0;
                e.ill  = !is_legal(insn_i);
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] w);
        valid_i = 1'b1;
        pc_i    = pc;
        insn_i  = w;
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; pc_i = '0; insn_i = '0;
        #3;
        check("rst valid_o", 32'(valid_o), 32'd0);
        check("rst ready_o", 32'(ready_o), 32'd1);
        check("rst pc_o", pc_o, 32'd0);
        check("rst insn_o", insn_o, 32'd0);
        check("rst imm_o", imm_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(32'h01000000, 32'h00500093);
        @(negedge clk);
        check("addi valid", 32'(valid_o), 32'd1);
        check("addi opcode", 32'(opcode_o), 32'h13);
        check("addi rd", 32'(rd_o), 32'd1);
        check("addi rs1", 32'(rs1_o), 32'd0);
        check("addi funct3", 32'(funct3_o), 32'd0);
        check("addi imm", imm_o, 32'h5);
        check("addi illegal", 32'(illegal_o), 32'd0);
        check("addi pc", pc_o, 32'h01000000);
        step();

        send(32'h01000004, 32'hFE208EE3);
        @(negedge clk);
        check("beq opcode", 32'(opcode_o), 32'h63);
        check("beq rs1", 32'(rs1_o), 32'd1);
        check("beq rs2", 32'(rs2_o), 32'd2);
        check("beq imm", imm_o, 32'hFFFFFFFC);
        step();

        send(32'h01000008, 32'h123452B7);
        @(negedge clk);
        check("lui rd", 32'(rd_o), 32'd5);
        check("lui imm", imm_o, 32'h12345000);
        step();

        send(32'h0100000C, 32'h001000EF);
        @(negedge clk);
        check("jal imm", imm_o, 32'h00000800);
        step();

        send(32'h01000010, 32'h00000000);
        @(negedge clk);
        check("illegal flag", 32'(illegal_o), 32'd1);
        check("illegal imm", imm_o, 32'd0);
        step();
`ifdef DECODE_PERF_CNT_EN
        check("illegal_cnt one", illegal_cnt_o, 32'd1);
        check("decoded_cnt five", decoded_cnt_o, 32'd5);
`endif

        // Backpressure: three back-to-back pcs with a three-cycle stall.
        valid_i = 1'b1; pc_i = 32'h0; insn_i = 32'h00000013; ready_i = 1'b1;
        step();
        pc_i = 32'h4; ready_i = 1'b0;
        @(negedge clk);
        check("bp first valid", 32'(valid_o), 32'd1);
        check("bp stall pc 1", pc_o, 32'h0);
        step();
        pc_i = 32'h8;
        @(negedge clk);
        check("bp ready drop", 32'(ready_o), 32'd0);
        check("bp stall pc 2", pc_o, 32'h0);
        step();
        @(negedge clk);
        check("bp stall pc 3", pc_o, 32'h0);
        step();
        ready_i = 1'b1;
        @(negedge clk);
        check("bp release pc0", pc_o, 32'h0);
        step();
        @(negedge clk);
        check("bp release pc4", pc_o, 32'h4);
        check("bp ready back", 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("bp release pc8", pc_o, 32'h8);
        step();
        @(negedge clk);
        check("bp drained", 32'(valid_o), 32'd0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            pc_i    = $urandom & 32'hFFFFFFFC;
            insn_i  = rand_insn();
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) step();

        // Reset while FULL.
        ready_i = 1'b0; valid_i = 1'b1;
        pc_i = 32'h100; insn_i = 32'h00500093;
        step();
        pc_i = 32'h104; insn_i = 32'h123452B7;
        step();
        valid_i = 1'b0;
        check("pre-reset full", 32'(ready_o), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst valid_o", 32'(valid_o), 32'd0);
        check("arst ready_o", 32'(ready_o), 32'd1);
        check("arst pc_o", pc_o, 32'd0);
        check("arst insn_o", insn_o, 32'd0);
        check("arst imm_o", imm_o, 32'd0);
        check("arst illegal_o", 32'(illegal_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_i = 1'b1;
        send(32'h200, 32'h00000000);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
